// File: rtl/hazard5_bus_arbiter.sv
// rtl/hazard5_bus_arbiter.sv - AHB-Lite master arbiter, load/store over fetch priority
// Optional fetch anti-starvation counter: define HAZARD5_ARB_STARVE_LIMIT_EN.
module hazard5_bus_arbiter #(
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [W_ADDR-1:0] i_addr,
    input  logic              i_size,
    input  logic              i_addr_vld,
    output logic              i_addr_rdy,
    output logic [W_DATA-1:0] i_data,
    output logic              i_data_vld,

    input  logic [W_ADDR-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_write,
    input  logic              d_addr_vld,
    output logic              d_addr_rdy,
    input  logic [W_DATA-1:0] d_wdata,
    output logic [W_DATA-1:0] d_rdata,
    output logic              d_data_vld,
    output logic              d_err,
    output logic              i_err,

    output logic [W_ADDR-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    input  logic              hready,
    input  logic              hresp,
    output logic [W_DATA-1:0] hwdata,
    input  logic [W_DATA-1:0] hrdata
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    if (W_ADDR != 32 || W_DATA != 32 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("hazard5_bus_arbiter: unsupported parameterisation");
    end

    // Owner encoding throughout: 1 = load/store port, 0 = fetch port.
    logic aph_hold;
    logic aph_owner;
    logic dph_active;
    logic dph_owner;

    logic req;
    logic grant_d;
    logic pick_i;
    logic err_first;
    logic nonseq;
    logic accept;
    logic dph_done;

`ifdef HAZARD5_ARB_STARVE_LIMIT_EN
    localparam int W_STARVE = $clog2(STARVE_LIMIT + 1);
    localparam logic [W_STARVE-1:0] STARVE_MAX = W_STARVE'(STARVE_LIMIT);

    logic [W_STARVE-1:0] starve_ctr;

    assign pick_i = i_addr_vld && (starve_ctr == STARVE_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || !i_addr_vld) begin
            starve_ctr <= '0;
        end else if (accept && !grant_d) begin
            starve_ctr <= '0;
        end else if (accept && grant_d && starve_ctr != STARVE_MAX) begin
            starve_ctr <= starve_ctr + 1'b1;
        end
    end
`else
    assign pick_i = 1'b0;
`endif

    // A stalled address phase keeps its owner; otherwise load/store wins.
    always_comb begin
        req     = 1'b0;
        grant_d = 1'b0;
        if (aph_hold) begin
            req     = 1'b1;
            grant_d = aph_owner;
        end else if (d_addr_vld && !pick_i) begin
            req     = 1'b1;
            grant_d = 1'b1;
        end else if (i_addr_vld) begin
            req     = 1'b1;
            grant_d = 1'b0;
        end
    end

    // First cycle of a two-cycle error response cancels the pending address.
    assign err_first = dph_active && hresp && !hready;
    assign nonseq    = req && rst_n && !err_first;
    assign accept    = nonseq && hready;
    assign dph_done  = rst_n && dph_active && hready;

    assign htrans = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr  = grant_d ? d_addr : i_addr;
    assign hwrite = nonseq && grant_d && d_write;
    assign hsize  = grant_d ? {1'b0, d_size} : (i_size ? 3'd2 : 3'd1);
    assign hwdata = d_wdata;

    assign d_addr_rdy = nonseq && grant_d && hready;
    assign i_addr_rdy = nonseq && !grant_d && hready;

    assign d_data_vld = dph_done && dph_owner;
    assign i_data_vld = dph_done && !dph_owner;
    assign d_err      = d_data_vld && hresp;
    assign i_err      = i_data_vld && hresp;
    assign d_rdata    = hrdata;
    assign i_data     = hrdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aph_hold   <= 1'b0;
            aph_owner  <= 1'b0;
            dph_active <= 1'b0;
            dph_owner  <= 1'b0;
        end else if (accept) begin
            dph_active <= 1'b1;
            dph_owner  <= grant_d;
            aph_hold   <= 1'b0;
        end else begin
            if (hready) begin
                dph_active <= 1'b0;
            end
            if (nonseq) begin
                aph_hold  <= 1'b1;
                aph_owner <= grant_d;
            end else begin
                aph_hold  <= 1'b0;
            end
        end
    end

endmodule
